// File: rtl/ibex_cheri_cap_access_seq_pkg.sv
// Shared types and constants for the capability access sequencer.
// Capabilities are moved as two bus words plus a tag; exception bits mirror the checker's encoding.
package ibex_cheri_cap_access_seq_pkg;

  localparam int unsigned CapAccessBytes = 8;
  localparam int unsigned CheriExcWidth  = 5;

  localparam logic [CheriExcWidth-1:0] CheriExcTag    = 5'b00001;
  localparam logic [CheriExcWidth-1:0] CheriExcSeal   = 5'b00010;
  localparam logic [CheriExcWidth-1:0] CheriExcPerm   = 5'b00100;
  localparam logic [CheriExcWidth-1:0] CheriExcLength = 5'b01000;
  localparam logic [CheriExcWidth-1:0] CheriExcAlign  = 5'b10000;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'd0,
    CS_REQ_LO  = 3'd1,
    CS_WAIT_LO = 3'd2,
    CS_REQ_HI  = 3'd3,
    CS_WAIT_HI = 3'd4,
    CS_RESP    = 3'd5
  } cap_seq_state_e;

  function automatic logic cap_misaligned(input logic [31:0] addr);
    return addr[$clog2(CapAccessBytes)-1:0] != '0;
  endfunction

endpackage

// File: rtl/ibex_cheri_cap_access_seq_if.sv
// LSU-side and data-bus-side signals of the capability access sequencer.
// master is the sequencer's view; slave is the view of the LSU/bus/checker around it.
interface ibex_cheri_cap_access_seq_if;
  import ibex_cheri_cap_access_seq_pkg::*;

  logic                     lsu_req_i;
  logic                     lsu_gnt_o;
  logic                     lsu_we_i;
  logic [31:0]              lsu_addr_i;
  logic [63:0]              lsu_wdata_i;
  logic                     lsu_wtag_i;
  logic                     lsu_rvalid_o;
  logic [63:0]              lsu_rdata_o;
  logic                     lsu_rtag_o;
  logic                     lsu_err_o;
  logic [CheriExcWidth-1:0] lsu_cheri_exc_o;
  logic                     data_req_o;
  logic                     data_gnt_i;
  logic                     data_rvalid_i;
  logic [31:0]              data_addr_o;
  logic                     data_we_o;
  logic [3:0]               data_be_o;
  logic [31:0]              data_wdata_o;
  logic                     data_wtag_o;
  logic [31:0]              data_rdata_i;
  logic                     data_rtag_i;
  logic                     data_err_i;
  logic                     chk_first_access_o;
  logic [CheriExcWidth-1:0] chk_exc_i;
  logic                     busy_o;

  modport master (
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wtag_i,
           data_gnt_i, data_rvalid_i, data_rdata_i, data_rtag_i, data_err_i, chk_exc_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_rtag_o, lsu_err_o, lsu_cheri_exc_o,
           data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o, data_wtag_o,
           chk_first_access_o, busy_o
  );

  modport slave (
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wtag_i,
           data_gnt_i, data_rvalid_i, data_rdata_i, data_rtag_i, data_err_i, chk_exc_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_rtag_o, lsu_err_o, lsu_cheri_exc_o,
           data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o, data_wtag_o,
           chk_first_access_o, busy_o
  );

endinterface

// File: rtl/ibex_cheri_cap_access_seq.sv
// Splits one capability load/store into two 32-bit bus transactions (low word first)
// and returns a single merged 64-bit + tag response to the LSU.
module ibex_cheri_cap_access_seq
  import ibex_cheri_cap_access_seq_pkg::*;
#(
  parameter int unsigned CapMemWidth = 64,
  parameter int unsigned BusWidth    = 32
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  ibex_cheri_cap_access_seq_if.master bus
);

  if (CapMemWidth != 2 * BusWidth) begin : g_width_check
    $error("CapMemWidth must be exactly twice BusWidth");
  end

  cap_seq_state_e           state_q, state_d;
  logic                     we_q;
  logic [31:0]              addr_q;
  logic [CapMemWidth-1:0]   wdata_q;
  logic                     wtag_q;
  logic [BusWidth-1:0]      rdata_lo_q, rdata_hi_q;
  logic                     rtag_lo_q, rtag_hi_q;
  logic [CheriExcWidth-1:0] exc_q;
  logic                     err_q;

  logic                     capture, latch_lo, latch_hi, fault;
  logic                     lsu_gnt, lsu_rvalid, lsu_rtag, lsu_err;
  logic [CapMemWidth-1:0]   lsu_rdata;
  logic [CheriExcWidth-1:0] lsu_exc;
  logic                     data_req, data_we, data_wtag, chk_first;
  logic [31:0]              data_addr;
  logic [BusWidth-1:0]      data_wdata;
  logic [3:0]               data_be;

  // A faulting access never exposes partially loaded data or a tag.
  assign fault = err_q | (|exc_q);

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    latch_lo   = 1'b0;
    latch_hi   = 1'b0;
    lsu_gnt    = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    lsu_rtag   = 1'b0;
    lsu_err    = 1'b0;
    lsu_exc    = '0;
    data_req   = 1'b0;
    data_addr  = '0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_wdata = '0;
    data_wtag  = 1'b0;
    chk_first  = 1'b0;

    unique case (state_q)
      CS_IDLE: begin
        lsu_gnt = bus.lsu_req_i & rst_ni;
        if (lsu_gnt) begin
          capture = 1'b1;
          state_d = cap_misaligned(bus.lsu_addr_i) ? CS_RESP : CS_REQ_LO;
        end
      end
      CS_REQ_LO: begin
        data_req   = 1'b1;
        data_addr  = addr_q;
        data_we    = we_q;
        data_be    = 4'hF;
        data_wdata = wdata_q[BusWidth-1:0];
        data_wtag  = wtag_q;
        chk_first  = 1'b1;
        if (bus.data_gnt_i) state_d = CS_WAIT_LO;
      end
      CS_WAIT_LO: begin
        if (bus.data_rvalid_i) begin
          latch_lo = 1'b1;
          state_d  = ((|bus.chk_exc_i) || bus.data_err_i) ? CS_RESP : CS_REQ_HI;
        end
      end
      CS_REQ_HI: begin
        data_req   = 1'b1;
        data_addr  = addr_q + 32'd4;
        data_we    = we_q;
        data_be    = 4'hF;
        data_wdata = wdata_q[CapMemWidth-1:BusWidth];
        data_wtag  = wtag_q;
        if (bus.data_gnt_i) state_d = CS_WAIT_HI;
      end
      CS_WAIT_HI: begin
        if (bus.data_rvalid_i) begin
          latch_hi = 1'b1;
          state_d  = CS_RESP;
        end
      end
      CS_RESP: begin
        lsu_rvalid = 1'b1;
        lsu_rdata  = fault ? '0 : {rdata_hi_q, rdata_lo_q};
        lsu_rtag   = fault ? 1'b0 : (rtag_lo_q & rtag_hi_q);
        lsu_err    = err_q;
        lsu_exc    = exc_q;
        state_d    = CS_IDLE;
      end
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CS_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wtag_q     <= 1'b0;
      rdata_lo_q <= '0;
      rdata_hi_q <= '0;
      rtag_lo_q  <= 1'b0;
      rtag_hi_q  <= 1'b0;
      exc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        we_q       <= bus.lsu_we_i;
        addr_q     <= bus.lsu_addr_i;
        wdata_q    <= bus.lsu_wdata_i;
        wtag_q     <= bus.lsu_wtag_i;
        err_q      <= cap_misaligned(bus.lsu_addr_i);
        exc_q      <= '0;
        rdata_lo_q <= '0;
        rdata_hi_q <= '0;
        rtag_lo_q  <= 1'b0;
        rtag_hi_q  <= 1'b0;
      end
      if (latch_lo) begin
        rdata_lo_q <= bus.data_rdata_i;
        rtag_lo_q  <= bus.data_rtag_i;
        exc_q      <= bus.chk_exc_i;
        err_q      <= bus.data_err_i;
      end
      if (latch_hi) begin
        rdata_hi_q <= bus.data_rdata_i;
        rtag_hi_q  <= bus.data_rtag_i;
        err_q      <= err_q | bus.data_err_i;
      end
    end
  end

  assign bus.lsu_gnt_o          = lsu_gnt;
  assign bus.lsu_rvalid_o       = lsu_rvalid;
  assign bus.lsu_rdata_o        = lsu_rdata;
  assign bus.lsu_rtag_o         = lsu_rtag;
  assign bus.lsu_err_o          = lsu_err;
  assign bus.lsu_cheri_exc_o    = lsu_exc;
  assign bus.data_req_o         = data_req;
  assign bus.data_addr_o        = data_addr;
  assign bus.data_we_o          = data_we;
  assign bus.data_be_o          = data_be;
  assign bus.data_wdata_o       = data_wdata;
  assign bus.data_wtag_o        = data_wtag;
  assign bus.chk_first_access_o = chk_first;
  assign bus.busy_o             = (state_q != CS_IDLE);

  // A bus response is only meaningful while a word is outstanding.
  a_rvalid_when_waiting: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.data_rvalid_i |-> (state_q == CS_WAIT_LO || state_q == CS_WAIT_HI));

endmodule
